// File: rtl/scfifo_ctrl.sv
// Pointer and flag controller for a single-clock FIFO around a dual-port memory whose
// read port registers its address; data moves between requester and memory directly.
module scfifo_ctrl #(
    parameter int unsigned L        = 5,
    parameter int unsigned AF_LEVEL = 28,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    output logic         wr_n,
    output logic [L-1:0] wr_addr,
    output logic         rd_n,
    output logic [L-1:0] rd_addr,
    output logic         rvalid,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [L:0]   count,
    output logic         overflow,
    output logic         underflow
);
    localparam int unsigned DEPTH     = 2 ** L;
    localparam logic [L:0]   DEPTH_CNT = (L+1)'(DEPTH);
    localparam logic [L:0]   AF_CNT    = (L+1)'(AF_LEVEL);
    localparam logic [L:0]   AE_CNT    = (L+1)'(AE_LEVEL);
    localparam logic [L-1:0] PTR_ONE   = {{(L-1){1'b0}}, 1'b1};
    localparam logic [L:0]   CNT_ONE   = {{L{1'b0}}, 1'b1};

    logic [L-1:0] wr_ptr_q, wr_ptr_d;
    logic [L-1:0] rd_ptr_q, rd_ptr_d;
    logic [L:0]   count_q, count_d;
    logic         rvalid_q, overflow_q, underflow_q;
    logic         wa, ra;

    // Flags decode the registered count only, so they move the cycle after an access.
    always_comb begin
        full         = (count_q == DEPTH_CNT);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_CNT);
        almost_empty = (count_q <= AE_CNT);
    end

    // No bypass: a full FIFO refuses a push and an empty one refuses a pop regardless of
    // the opposite request, which keeps read and write off the same address.
    always_comb begin
        wa = push & ~full & ~rst;
        ra = pop & ~empty & ~rst;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wa) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (ra) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wa, ra})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rvalid_q    <= ra;
            overflow_q  <= push & full;
            underflow_q <= pop & empty;
        end
    end

    always_comb begin
        wr_n      = ~wa;
        wr_addr   = wr_ptr_q;
        rd_n      = ~ra;
        rd_addr   = rd_ptr_q;
        rvalid    = rvalid_q;
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_scfifo_ctrl.sv
// Directed bench for scfifo_ctrl: vector table for basic traffic plus loops for fill,
// simultaneous push/pop at the limits, pointer wrap and mid-traffic reset.
module tb_scfifo_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       wr_n, rd_n, rvalid, full, empty, almost_full, almost_empty;
    logic       overflow, underflow;
    logic [4:0] wr_addr, rd_addr;
    logic [5:0] count;

    logic [7:0] mem [32];
    logic [7:0] rdata;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic       rst, push, pop;
        logic [7:0] data;
        logic       wr_n;
        logic [4:0] wr_addr;
        logic       rd_n;
        logic [4:0] rd_addr;
        logic       rvalid;
        logic [5:0] count;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs [$];

    scfifo_ctrl #(.L(5), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .wr_n         (wr_n),
        .wr_addr      (wr_addr),
        .rd_n         (rd_n),
        .rd_addr      (rd_addr),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Memory model: write port and registered-address read port.
    always @(posedge clk) begin
        if (wr_n === 1'b0) mem[wr_addr] <= wdata;
        if (rd_n === 1'b0) rdata <= mem[rd_addr];
    end

    // Expected read order is the order of accepted writes; reset discards everything.
    always @(posedge clk) begin
        if (rst) exp_q.delete();
        else if (wr_n === 1'b0) exp_q.push_back(wdata);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdata_unexpected got=%0h exp=none", rdata);
            end else begin
                chk("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive(input logic r, input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        rst   = r;
        push  = p;
        pop   = q;
        wdata = d;
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_wr_n, input logic [4:0] e_wa,
                             input logic e_rd_n, input logic [4:0] e_ra, input logic e_rv,
                             input logic [5:0] e_cnt, input logic e_ovf, input logic e_unf);
        chk({tag, ".wr_n"}, {31'd0, wr_n}, {31'd0, e_wr_n});
        chk({tag, ".wr_addr"}, {27'd0, wr_addr}, {27'd0, e_wa});
        chk({tag, ".rd_n"}, {31'd0, rd_n}, {31'd0, e_rd_n});
        chk({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, e_ra});
        chk({tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, e_rv});
        chk({tag, ".count"}, {26'd0, count}, {26'd0, e_cnt});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e_ovf});
        chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, e_unf});
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, e_cnt == 6'd0});
        chk({tag, ".full"}, {31'd0, full}, {31'd0, e_cnt == 6'd32});
        chk({tag, ".almost_full"}, {31'd0, almost_full}, {31'd0, e_cnt >= 6'd28});
        chk({tag, ".almost_empty"}, {31'd0, almost_empty}, {31'd0, e_cnt <= 6'd4});
    endtask

    initial begin
        // rst push pop data | wr_n wr_addr rd_n rd_addr rvalid count ovf unf
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 6'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 6'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 6'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd3, 1'b0, 5'd1, 1'b1, 6'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd3, 1'b0, 5'd2, 1'b1, 6'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 6'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 6'd0, 1'b0, 1'b0});
        // Pop while empty, then push and pop together while empty.
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 6'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 6'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hB1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 6'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 6'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 5'd4, 1'b0, 5'd3, 1'b0, 6'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 6'd0, 1'b0, 1'b0});

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].data);
            check_out($sformatf("vec%0d", i), vecs[i].wr_n, vecs[i].wr_addr, vecs[i].rd_n,
                      vecs[i].rd_addr, vecs[i].rvalid, vecs[i].count, vecs[i].ovf,
                      vecs[i].unf);
        end

        // Fill to full from pointer 4, then one refused push.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
            check_out($sformatf("fill%0d", i), 1'b0, 5'((4 + i) % 32), 1'b1, 5'd4, 1'b0,
                      6'(i), 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 8'hEE);
        check_out("push_full", 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 6'd32, 1'b0, 1'b0);

        // Push and pop together while full: only the read goes through.
        drive(1'b0, 1'b1, 1'b1, 8'hEF);
        check_out("pp_full", 1'b1, 5'd4, 1'b0, 5'd4, 1'b0, 6'd32, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_out("pp_full_after", 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 6'd31, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_out("ovf_clear", 1'b1, 5'd4, 1'b1, 5'd5, 1'b0, 6'd31, 1'b0, 1'b0);

        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            check_out($sformatf("drain%0d", i), 1'b1, 5'd4, 1'b0, 5'((5 + i) % 32),
                      i > 0, 6'(31 - i), 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_out("drained", 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 6'd0, 1'b0, 1'b0);

        // 40 writes interleaved with reads at occupancy 2; both pointers wrap.
        for (int k = 0; k < 42; k++) begin
            int e_cnt;
            e_cnt = (k < 2) ? k : ((k <= 40) ? 2 : 1);
            drive(1'b0, k < 40, k >= 2, 8'(8'h40 + k));
            check_out($sformatf("wrap%0d", k), !(k < 40), 5'((4 + ((k < 40) ? k : 40)) % 32),
                      !(k >= 2), 5'((4 + ((k >= 2) ? k - 2 : 0)) % 32), k >= 3,
                      6'(e_cnt), 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_out("wrap_end0", 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 6'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_out("wrap_end1", 1'b1, 5'd12, 1'b1, 5'd12, 1'b0, 6'd0, 1'b0, 1'b0);

        // Reset with 10 entries and a read in flight.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
            check_out($sformatf("load%0d", i), 1'b0, 5'(12 + i), 1'b1, 5'd12, 1'b0,
                      6'(i), 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        check_out("pre_rst_pop", 1'b1, 5'd22, 1'b0, 5'd12, 1'b0, 6'd10, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h99);
        check_out("in_rst", 1'b1, 5'd22, 1'b1, 5'd13, 1'b1, 6'd9, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_out("post_rst", 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check_out("post_rst_idle", 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        chk("queue_cleared", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
